pipeline_debug_ctrl: RTL and testbench

Debug controller that sequences the MIPS pipeline and the register file from a byte-command stream. It gates the global pipeline enable for free-run and single-step execution and stops the pipeline on halt. After each run or step, and on request, it dumps PC, cycle count and all 32 registers over a byte-wide valid/ready transmit port. It sits between the UART byte layer and the pipeline top; it drives the register file's debug read port.

---
 rtl/pipeline_debug_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - byte-command debug sequencer for the MIPS pipeline with PC/count/register dump
module pipeline_debug_ctrl #(
   parameter int N_BITS     = 32,
   parameter int N_REG_BITS = 5,
   parameter int N_REGS     = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [7:0]            i_cmd,
   input  logic                  i_cmd_valid,
   input  logic                  i_halt,
   input  logic [N_BITS-1:0]     i_pc,
   input  logic [N_BITS-1:0]     i_reg_data,
   input  logic                  i_tx_ready,
   output logic                  o_pipe_enable,
   output logic [N_REG_BITS-1:0] o_reg_addr,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   output logic                  o_busy,
   output logic                  o_halted,
   output logic [N_BITS-1:0]     o_cycle_count
);

   // Word index covers PC, cycle count and every register.
   localparam int                W_BITS    = $clog2(N_REGS + 2);
   localparam logic [W_BITS-1:0] LAST_WORD = W_BITS'(N_REGS + 1);
   localparam logic [7:0]        CMD_RUN   = 8'h43;
   localparam logic [7:0]        CMD_STEP  = 8'h53;
   localparam logic [7:0]        CMD_DUMP  = 8'h44;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_DUMP_ADDR,
      S_DUMP_LATCH,
      S_DUMP_SEND,
      S_HALTED
   } state_t;

   state_t                  state_q, state_d;
   logic [W_BITS-1:0]       word_q, word_d;
   logic [1:0]              byte_q, byte_d;
   logic [N_BITS-1:0]       shift_q, shift_d;
   logic [N_REG_BITS-1:0]   reg_addr_q, reg_addr_d;
   logic                    halted_q, halted_d;
   logic [N_BITS-1:0]       cycle_q, cycle_d;
   logic                    pipe_en;

   // The pipeline never advances in a cycle where it reports halt.
   assign pipe_en = ((state_q == S_RUN) || (state_q == S_STEP)) && !i_halt;

   // Enabled-cycle counter; wraps naturally, cleared only by reset.
   always_comb begin
      cycle_d = cycle_q;
      if (pipe_en) begin
         cycle_d = cycle_q + N_BITS'(1);
      end
   end

   // Next-state logic: command decode, run/step sequencing and the dump walk.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      byte_d     = byte_q;
      shift_d    = shift_q;
      reg_addr_d = reg_addr_q;
      halted_d   = halted_q;
      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               if (i_cmd == CMD_RUN) begin
                  state_d = S_RUN;
               end else if (i_cmd == CMD_STEP) begin
                  state_d = S_STEP;
               end else if (i_cmd == CMD_DUMP) begin
                  state_d = S_DUMP_ADDR;
                  word_d  = '0;
               end
            end
         end
         S_HALTED: begin
            if (i_cmd_valid && (i_cmd == CMD_DUMP)) begin
               state_d = S_DUMP_ADDR;
               word_d  = '0;
            end
         end
         S_RUN: begin
            if (i_halt) begin
               halted_d = 1'b1;
               state_d  = S_DUMP_ADDR;
               word_d   = '0;
            end
         end
         S_STEP: begin
            if (i_halt) begin
               halted_d = 1'b1;
            end
            state_d = S_DUMP_ADDR;
            word_d  = '0;
         end
         S_DUMP_ADDR: begin
            // Register words start at index 2; address is parked at 0 for PC/count.
            reg_addr_d = (word_q >= W_BITS'(2)) ? N_REG_BITS'(word_q - W_BITS'(2)) : '0;
            state_d    = S_DUMP_LATCH;
         end
         S_DUMP_LATCH: begin
            if (word_q == W_BITS'(0)) begin
               shift_d = i_pc;
            end else if (word_q == W_BITS'(1)) begin
               shift_d = cycle_q;
            end else begin
               shift_d = i_reg_data;
            end
            byte_d  = 2'd0;
            state_d = S_DUMP_SEND;
         end
         S_DUMP_SEND: begin
            if (i_tx_ready) begin
               if (byte_q == 2'd3) begin
                  if (word_q == LAST_WORD) begin
                     state_d = halted_q ? S_HALTED : S_IDLE;
                  end else begin
                     word_d  = word_q + W_BITS'(1);
                     state_d = S_DUMP_ADDR;
                  end
               end else begin
                  byte_d  = byte_q + 2'd1;
                  shift_d = shift_q << 8;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         reg_addr_q <= '0;
         halted_q   <= 1'b0;
         cycle_q    <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         reg_addr_q <= reg_addr_d;
         halted_q   <= halted_d;
         cycle_q    <= cycle_d;
      end
   end

   assign o_pipe_enable = pipe_en;
   assign o_reg_addr    = reg_addr_q;
   assign o_tx_valid    = (state_q == S_DUMP_SEND);
   assign o_tx_data     = o_tx_valid ? shift_q[N_BITS-1 -: 8] : 8'h00;
   assign o_busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign o_halted      = halted_q;
   assign o_cycle_count = cycle_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb/tb_pipeline_debug_ctrl.sv - randomized self-checking bench for pipeline_debug_ctrl
module tb_pipeline_debug_ctrl;
   localparam int N_BITS     = 32;
   localparam int N_REG_BITS = 5;
   localparam int N_REGS     = 32;
   localparam int DUMP_BYTES = (N_REGS + 2) * 4;

   logic                  i_clk = 1'b0;
   logic                  i_reset = 1'b1;
   logic [7:0]            i_cmd = 8'h00;
   logic                  i_cmd_valid = 1'b0;
   logic                  i_halt = 1'b0;
   logic [N_BITS-1:0]     i_pc = '0;
   logic [N_BITS-1:0]     i_reg_data;
   logic                  i_tx_ready = 1'b1;
   logic                  o_pipe_enable;
   logic [N_REG_BITS-1:0] o_reg_addr;
   logic [7:0]            o_tx_data;
   logic                  o_tx_valid;
   logic                  o_busy;
   logic                  o_halted;
   logic [N_BITS-1:0]     o_cycle_count;

   logic [N_BITS-1:0] reg_mem [N_REGS];
   logic [N_BITS-1:0] model_count;
   logic [7:0]        exp_q[$];
   logic [7:0]        got_q[$];
   int                vectors = 0;
   int                miscompares = 0;
   int                en_cnt = 0;

   pipeline_debug_ctrl #(.N_BITS(N_BITS), .N_REG_BITS(N_REG_BITS), .N_REGS(N_REGS)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
      .i_halt(i_halt), .i_pc(i_pc), .i_reg_data(i_reg_data), .i_tx_ready(i_tx_ready),
      .o_pipe_enable(o_pipe_enable), .o_reg_addr(o_reg_addr), .o_tx_data(o_tx_data),
      .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_halted(o_halted),
      .o_cycle_count(o_cycle_count)
   );

   assign i_reg_data = reg_mem[o_reg_addr];

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_pipe_enable === 1'b1) en_cnt++;
   end

   // Expected dump: PC, cycle count, then every register, each word MSB first.
   function automatic void build_dump(input logic [N_BITS-1:0] pc, input logic [N_BITS-1:0] cnt);
      logic [N_BITS-1:0] w;
      exp_q.delete();
      for (int k = 0; k < N_REGS + 2; k++) begin
         if (k == 0) w = pc;
         else if (k == 1) w = cnt;
         else w = reg_mem[k-2];
         for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
      end
   endfunction

   function automatic int first_diff(input int n);
      for (int i = 0; i < n; i++) begin
         if (i >= got_q.size()) return i;
         if (got_q[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] got_at(input int i);
      logic [7:0] v;
      v = 8'hxx;
      if (i >= 0 && i < got_q.size()) v = got_q[i];
      return v;
   endfunction

   task automatic randomize_state();
      i_pc = $urandom;
      for (int i = 0; i < N_REGS; i++) reg_mem[i] = $urandom;
   endtask

   task automatic apply_cmd(input logic [7:0] c);
      @(negedge i_clk);
      i_cmd       = c;
      i_cmd_valid = 1'b1;
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
   endtask

   // Sink: mode 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready.
   task automatic collect(input int mode, input int limit, output int hold_errs, output int first_cyc);
      int         cyc;
      logic       stalled;
      logic       rdy;
      logic [7:0] held;
      cyc = 0; stalled = 1'b0; held = 8'h00; hold_errs = 0; first_cyc = -1;
      got_q.delete();
      while (got_q.size() < limit && cyc < 4000) begin
         @(negedge i_clk);
         cyc++;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         if (o_tx_valid === 1'b1) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (stalled && (o_tx_data !== held)) hold_errs++;
            if (rdy) begin
               got_q.push_back(o_tx_data);
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = o_tx_data;
            end
         end else if (stalled) begin
            hold_errs++;
            stalled = 1'b0;
         end
         i_tx_ready = rdy;
      end
      i_tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      vectors++;
      if ({o_pipe_enable, o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_halted, o_cycle_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got en=%b addr=%0d data=%02h valid=%b busy=%b halted=%b count=%08h, expected all zero",
                  o_pipe_enable, o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_halted, o_cycle_count);
      end
      i_reset = 1'b0;
      model_count = '0;
      @(negedge i_clk);
   endtask

   task automatic test_step();
      int base, herr, fc, bad;
      i_pc = 32'h0000_0004;
      for (int i = 0; i < N_REGS; i++) reg_mem[i] = 32'h100 + i;
      base = en_cnt;
      model_count = model_count + 1;
      build_dump(i_pc, model_count);
      apply_cmd(8'h53);
      collect(0, DUMP_BYTES, herr, fc);
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL step_bytes: byte %0d got %02h expected %02h", bad, got_at(bad), exp_q[bad]);
      end
      @(negedge i_clk);
      vectors++;
      if (en_cnt - base != 1) begin
         miscompares++;
         $display("FAIL step_enable_cycles: got %0d expected 1", en_cnt - base);
      end
      vectors++;
      if ({o_busy, o_halted} !== 2'b00 || o_cycle_count !== model_count) begin
         miscompares++;
         $display("FAIL step_end: got busy=%b halted=%b count=%08h expected 0 0 %08h", o_busy, o_halted, o_cycle_count, model_count);
      end
   endtask

   task automatic test_backpressure();
      int herr, fc, bad;
      randomize_state();
      build_dump(i_pc, model_count);
      apply_cmd(8'h44);
      vectors++;
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_dump_addr: got valid=%b busy=%b expected 0 1", o_tx_valid, o_busy);
      end
      @(negedge i_clk);
      vectors++;
      if (o_tx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_dump_latch: got valid=%b expected 0", o_tx_valid);
      end
      collect(1, DUMP_BYTES, herr, fc);
      vectors++;
      if (fc != 1) begin
         miscompares++;
         $display("FAIL bp_first_byte_latency: first valid at sink cycle %0d expected 1", fc);
      end
      vectors++;
      if (herr != 0) begin
         miscompares++;
         $display("FAIL bp_hold: got %0d hold violations expected 0", herr);
      end
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL bp_bytes: byte %0d got %02h expected %02h", bad, got_at(bad), exp_q[bad]);
      end
      @(negedge i_clk);
      vectors++;
      if (o_busy !== 1'b0 || o_cycle_count !== model_count) begin
         miscompares++;
         $display("FAIL bp_end: got busy=%b count=%08h expected 0 %08h", o_busy, o_cycle_count, model_count);
      end
   endtask

   task automatic test_busy_drop();
      int base, herr, fc, bad;
      randomize_state();
      base = en_cnt;
      build_dump(i_pc, model_count);
      apply_cmd(8'h44);
      fork
         collect(2, DUMP_BYTES, herr, fc);
         begin
            repeat (20) @(negedge i_clk);
            apply_cmd(8'h53);
         end
      join
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0 || herr != 0) begin
         miscompares++;
         $display("FAIL busy_drop_bytes: byte %0d got %02h expected %02h hold_errs %0d", bad, got_at(bad), (bad >= 0) ? exp_q[bad] : 8'h00, herr);
      end
      repeat (3) @(negedge i_clk);
      vectors++;
      if (en_cnt != base || o_busy !== 1'b0 || o_cycle_count !== model_count) begin
         miscompares++;
         $display("FAIL busy_drop_end: got enables=%0d busy=%b count=%08h expected 0 0 %08h", en_cnt - base, o_busy, o_cycle_count, model_count);
      end
   endtask

   task automatic test_ignored_bytes();
      int         base;
      logic [7:0] c;
      for (int n = 0; n < 4; n++) begin
         do c = 8'($urandom_range(0, 255)); while (c == 8'h43 || c == 8'h53 || c == 8'h44);
         base = en_cnt;
         apply_cmd(c);
         repeat (3) @(negedge i_clk);
         vectors++;
         if (o_busy !== 1'b0 || en_cnt != base) begin
            miscompares++;
            $display("FAIL ignored_byte_%02h: got busy=%b enables=%0d expected 0 0", c, o_busy, en_cnt - base);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base, herr, fc, bad;
      for (int n = 0; n < 3; n++) begin
         randomize_state();
         base = en_cnt;
         model_count = model_count + 1;
         build_dump(i_pc, model_count);
         apply_cmd(8'h53);
         collect(2, DUMP_BYTES, herr, fc);
         bad = first_diff(DUMP_BYTES);
         vectors++;
         if (bad >= 0 || herr != 0) begin
            miscompares++;
            $display("FAIL b2b_%0d_bytes: byte %0d got %02h expected %02h hold_errs %0d", n, bad, got_at(bad), (bad >= 0) ? exp_q[bad] : 8'h00, herr);
         end
         vectors++;
         if (en_cnt - base != 1) begin
            miscompares++;
            $display("FAIL b2b_%0d_enables: got %0d expected 1", n, en_cnt - base);
         end
      end
      @(negedge i_clk);
   endtask

   task automatic test_run_halt();
      int base, herr, fc, bad, n;
      randomize_state();
      n = $urandom_range(2, 20);
      base = en_cnt;
      apply_cmd(8'h43);
      repeat (n - 1) @(posedge i_clk);
      #1 i_halt = 1'b1;
      model_count = model_count + N_BITS'(n - 1);
      build_dump(i_pc, model_count);
      collect(0, DUMP_BYTES, herr, fc);
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL run_bytes: byte %0d got %02h expected %02h", bad, got_at(bad), exp_q[bad]);
      end
      @(negedge i_clk);
      vectors++;
      if (en_cnt - base != n - 1) begin
         miscompares++;
         $display("FAIL run_enable_cycles: got %0d expected %0d", en_cnt - base, n - 1);
      end
      vectors++;
      if ({o_busy, o_halted} !== 2'b01 || o_cycle_count !== model_count) begin
         miscompares++;
         $display("FAIL run_end: got busy=%b halted=%b count=%08h expected 0 1 %08h", o_busy, o_halted, o_cycle_count, model_count);
      end
      i_halt = 1'b0;
   endtask

   task automatic test_halted_cmds();
      int base, herr, fc, bad;
      base = en_cnt;
      apply_cmd(8'h43);
      repeat (3) @(negedge i_clk);
      apply_cmd(8'h53);
      repeat (3) @(negedge i_clk);
      vectors++;
      if (en_cnt != base || o_busy !== 1'b0 || o_halted !== 1'b1) begin
         miscompares++;
         $display("FAIL halted_ignore: got enables=%0d busy=%b halted=%b expected 0 0 1", en_cnt - base, o_busy, o_halted);
      end
      randomize_state();
      build_dump(i_pc, model_count);
      apply_cmd(8'h44);
      collect(2, DUMP_BYTES, herr, fc);
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0 || herr != 0) begin
         miscompares++;
         $display("FAIL halted_dump_bytes: byte %0d got %02h expected %02h hold_errs %0d", bad, got_at(bad), (bad >= 0) ? exp_q[bad] : 8'h00, herr);
      end
      @(negedge i_clk);
      vectors++;
      if ({o_busy, o_halted} !== 2'b01) begin
         miscompares++;
         $display("FAIL halted_dump_end: got busy=%b halted=%b expected 0 1", o_busy, o_halted);
      end
   endtask

   task automatic test_reset_mid_dump();
      int herr, fc, bad;
      randomize_state();
      build_dump(i_pc, model_count);
      apply_cmd(8'h44);
      collect(0, 50, herr, fc);
      bad = first_diff(50);
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL pre_reset_bytes: byte %0d got %02h expected %02h", bad, got_at(bad), exp_q[bad]);
      end
      @(posedge i_clk);
      #2 i_reset = 1'b1;
      #1;
      vectors++;
      if ({o_pipe_enable, o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_halted, o_cycle_count} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got en=%b addr=%0d data=%02h valid=%b busy=%b halted=%b count=%08h, expected all zero",
                  o_pipe_enable, o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_halted, o_cycle_count);
      end
      model_count = '0;
      @(negedge i_clk);
      i_reset = 1'b0;
      build_dump(i_pc, model_count);
      apply_cmd(8'h44);
      collect(0, DUMP_BYTES, herr, fc);
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL post_reset_bytes: byte %0d got %02h expected %02h", bad, got_at(bad), exp_q[bad]);
      end
      @(negedge i_clk);
   endtask

   task automatic test_wrap();
      int herr, fc, bad;
      @(negedge i_clk);
      force dut.cycle_q = '1;
      @(negedge i_clk);
      release dut.cycle_q;
      model_count = '1;
      @(negedge i_clk);
      vectors++;
      if (o_cycle_count !== model_count) begin
         miscompares++;
         $display("FAIL wrap_preload: got %08h expected %08h", o_cycle_count, model_count);
      end
      randomize_state();
      model_count = model_count + 1;
      build_dump(i_pc, model_count);
      apply_cmd(8'h53);
      collect(0, DUMP_BYTES, herr, fc);
      bad = first_diff(DUMP_BYTES);
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL wrap_bytes: byte %0d got %02h expected %02h", bad, got_at(bad), exp_q[bad]);
      end
      @(negedge i_clk);
      vectors++;
      if (o_cycle_count !== model_count) begin
         miscompares++;
         $display("FAIL wrap_count: got %08h expected %08h", o_cycle_count, model_count);
      end
   endtask

   initial begin
      for (int i = 0; i < N_REGS; i++) reg_mem[i] = '0;
      model_count = '0;
      test_reset();
      test_step();
      test_backpressure();
      test_busy_drop();
      test_ignored_bytes();
      test_back_to_back();
      test_run_halt();
      test_halted_cmds();
      test_reset_mid_dump();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
